// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit bitwise logic unit with valid/ready handshake.
// S1 registers operands and op; S2 registers the result and its zero flag.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             zero
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTX = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    op_e              op_q, op_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             zero_q, zero_d;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] result;

    // Ready depends only on the valid registers and out_ready, never on in_valid.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        result = '0;
        case (op_q)
            OP_AND:  result = x_q & y_q;
            OP_OR:   result = x_q | y_q;
            OP_NOR:  result = ~(x_q | y_q);
            OP_NAND: result = ~(x_q & y_q);
            OP_XOR:  result = x_q ^ y_q;
            OP_XNOR: result = ~(x_q ^ y_q);
            OP_NOTX: result = ~x_q;
            OP_PASS: result = x_q;
            default: result = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        x_d        = x_q;
        y_d        = y_q;
        op_d       = op_q;
        s2_valid_d = s2_valid_q;
        o_d        = o_q;
        zero_d     = zero_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                x_d  = x;
                y_d  = y;
                op_d = op_e'(op);
            end
        end

        // Data only loads on a real transfer so o/zero stay put under back-pressure.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                o_d    = result;
                zero_d = ~|result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            op_q       <= OP_AND;
            s2_valid_q <= 1'b0;
            o_q        <= '0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            x_q        <= x_d;
            y_q        <= y_d;
            op_q       <= op_d;
            s2_valid_q <= s2_valid_d;
            o_q        <= o_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign o         = o_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: WIDTH=4 main instance plus a WIDTH=8 instance.
module tb_logic_unit_pipe;

    typedef struct {
        logic [3:0] o;
        logic       z;
        int         cyc;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] o;
    logic       zero;

    logic       fixed_rdy;
    logic       rnd_rdy;
    logic       rnd_val;

    logic       in_valid8;
    logic       in_ready8;
    logic [7:0] x8;
    logic [7:0] y8;
    logic [2:0] op8;
    logic       out_valid8;
    logic       out_ready8;
    logic [7:0] o8;
    logic       zero8;

    int total;
    int bad;
    int cyc;

    logic [4:0] exp_q[$];
    obs_t       obs_q[$];

    logic_unit_pipe #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .zero(zero)
    );

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .x(x8), .y(y8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .o(o8), .zero(zero8)
    );

    assign out_ready = rnd_rdy ? rnd_val : fixed_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rnd_val <= 1'($urandom_range(0, 1));

    // A transfer seen at the negedge completes on the following posedge.
    initial cyc = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && out_valid && out_ready)
            obs_q.push_back('{o: o, z: zero, cyc: cyc});
    end

    function automatic logic [4:0] model(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        case (f)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = ~(a | b);
            3'b011:  r = ~(a & b);
            3'b100:  r = a ^ b;
            3'b101:  r = ~(a ^ b);
            3'b110:  r = ~a;
            default: r = a;
        endcase
        return {(r == 4'b0000), r};
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
        x = a; y = b; op = f; in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(f, a, b));
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        total++; bad++;
        $display("FAIL send_timeout: in_ready=%b required=1 within 100 cycles", in_ready);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%b exp=0", out_valid); end
        total++; if (o !== 4'h0) begin bad++; $display("FAIL reset_o: got=%h exp=0", o); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero: got=%b exp=0", zero); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b exp=1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nor();
        int n;
        obs_t ob;
        logic [4:0] e;
        fixed_rdy = 1'b1;
        send(4'b1111, 4'b0000, 3'b010);
        send(4'b0000, 4'b0110, 3'b010);
        total++; if (out_valid !== 1'b1 || o !== 4'b0000 || zero !== 1'b1) begin
            bad++; $display("FAIL nor_latency: valid=%b o=%b zero=%b exp valid=1 o=0000 zero=1", out_valid, o, zero);
        end
        n = exp_q.size();
        for (int c = 0; c < 200 && obs_q.size() < n; c++) @(posedge clk);
        repeat (3) @(posedge clk); #1;
        total++; if (obs_q.size() != n) begin bad++; $display("FAIL nor_count: got=%0d exp=%0d", obs_q.size(), n); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ob = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if ({ob.z, ob.o} !== e) begin bad++; $display("FAIL nor_result: got z=%b o=%b exp z=%b o=%b", ob.z, ob.o, e[4], e[3:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_all_ops();
        int n;
        int first;
        obs_t ob;
        logic [4:0] e;
        fixed_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send(4'b1100, 4'b1010, 3'(i));
        n = exp_q.size();
        for (int c = 0; c < 200 && obs_q.size() < n; c++) @(posedge clk);
        repeat (3) @(posedge clk); #1;
        total++; if (obs_q.size() != 8) begin bad++; $display("FAIL allops_count: got=%0d exp=8", obs_q.size()); end
        first = (obs_q.size() > 0) ? obs_q[0].cyc : 0;
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            ob = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if ({ob.z, ob.o} !== e || ob.cyc != first + i) begin
                bad++; $display("FAIL allops_result%0d: got o=%b z=%b cyc=%0d exp o=%b z=%b cyc=%0d", i, ob.o, ob.z, ob.cyc, e[3:0], e[4], first + i);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int n;
        obs_t ob;
        logic [4:0] e;
        fixed_rdy = 1'b0;
        send(4'b0000, 4'b0000, 3'b010);
        send(4'b1111, 4'b1111, 3'b000);
        x = 4'b1111; y = 4'b0000; op = 3'b100; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got=%b exp=0", in_ready); end
            total++; if (out_valid !== 1'b1 || o !== 4'b1111 || zero !== 1'b0) begin
                bad++; $display("FAIL bp_hold: valid=%b o=%b zero=%b exp valid=1 o=1111 zero=0", out_valid, o, zero);
            end
            @(posedge clk); #1;
        end
        fixed_rdy = 1'b1;
        send(4'b1111, 4'b0000, 3'b100);
        n = exp_q.size();
        for (int c = 0; c < 200 && obs_q.size() < n; c++) @(posedge clk);
        repeat (3) @(posedge clk); #1;
        total++; if (obs_q.size() != 3) begin bad++; $display("FAIL bp_count: got=%0d exp=3", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ob = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if ({ob.z, ob.o} !== e) begin bad++; $display("FAIL bp_result: got z=%b o=%b exp z=%b o=%b", ob.z, ob.o, e[4], e[3:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        fixed_rdy = 1'b0;
        send(4'b0011, 4'b0101, 3'b001);
        send(4'b0110, 4'b0101, 3'b100);
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got=%b exp=0", out_valid); end
        total++; if (o !== 4'h0 || zero !== 1'b0) begin bad++; $display("FAIL mid_o: o=%b zero=%b exp o=0000 zero=0", o, zero); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got=%b exp=1", in_ready); end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mid_no_output: got=%0d exp=0", obs_q.size()); end
        exp_q.delete(); obs_q.delete();
        #4 rst_n = 1'b1;
        fixed_rdy = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale: out_valid=%b exp=0", out_valid); end
            @(posedge clk); #1;
        end
        obs_q.delete();
    endtask

    task automatic test_width8();
        out_ready8 = 1'b1;
        total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL w8_in_ready: got=%b exp=1", in_ready8); end
        x8 = 8'hFF; y8 = 8'hFF; op8 = 3'b011; in_valid8 = 1'b1;
        @(posedge clk); #1;
        x8 = 8'hA5; y8 = 8'h0F;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        total++; if (out_valid8 !== 1'b1 || o8 !== 8'h00 || zero8 !== 1'b1) begin
            bad++; $display("FAIL w8_nand_ff: valid=%b o=%h zero=%b exp valid=1 o=00 zero=1", out_valid8, o8, zero8);
        end
        @(posedge clk); #1;
        total++; if (out_valid8 !== 1'b1 || o8 !== 8'hFA || zero8 !== 1'b0) begin
            bad++; $display("FAIL w8_nand_a5: valid=%b o=%h zero=%b exp valid=1 o=fa zero=0", out_valid8, o8, zero8);
        end
        @(posedge clk); #1;
        total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL w8_drain: out_valid=%b exp=0", out_valid8); end
    endtask

    task automatic test_random();
        int n;
        int errs;
        obs_t ob;
        logic [4:0] e;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(4'($urandom), 4'($urandom), 3'($urandom));
        end
        rnd_rdy = 1'b0;
        fixed_rdy = 1'b1;
        n = exp_q.size();
        for (int c = 0; c < 200 && obs_q.size() < n; c++) @(posedge clk);
        repeat (3) @(posedge clk); #1;
        total++; if (obs_q.size() != 1000) begin bad++; $display("FAIL rand_count: got=%0d exp=1000", obs_q.size()); end
        errs = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ob = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if ({ob.z, ob.o} !== e) begin
                bad++; errs++;
                if (errs <= 10) $display("FAIL rand_result: got z=%b o=%b exp z=%b o=%b", ob.z, ob.o, e[4], e[3:0]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; x = '0; y = '0; op = '0;
        fixed_rdy = 1'b1; rnd_rdy = 1'b0;
        in_valid8 = 1'b0; x8 = '0; y8 = '0; op8 = '0; out_ready8 = 1'b1;
        test_reset();
        test_nor();
        test_all_ops();
        test_backpressure();
        test_reset_midflight();
        test_width8();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
